// File: rtl/lif_step_if.sv
// Handshake bundle for lif_step_unit: sample in over in_valid/in_ready,
// membrane result out over out_valid/out_ready.
interface lif_step_if #(
  parameter int N = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] i_syn;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] v_pre;
  logic [N-1:0] v_out;
  logic         spike;

  modport master (
    output in_valid, i_syn, out_ready,
    input  in_ready, out_valid, v_pre, v_out, spike
  );

  modport slave (
    input  in_valid, i_syn, out_ready,
    output in_ready, out_valid, v_pre, v_out, spike
  );
endinterface

// File: rtl/lif_step_unit.sv
// Leaky integrate-and-fire Euler step on sign-magnitude fixed point, one shared multiplier.
// Define LIF_SATURATE_EN to clamp overflowing add/mult magnitudes instead of wrapping.
module lif_step_unit #(
  parameter int           N       = 32,
  parameter int           Q       = 16,
  parameter logic [N-1:0] V_REST  = 32'h8041_0000,
  parameter logic [N-1:0] V_TH    = 32'h8032_0000,
  parameter logic [N-1:0] V_RESET = 32'h8046_0000,
  parameter logic [N-1:0] LEAK    = 32'h0000_1999,
  parameter logic [N-1:0] GAIN    = 32'h0001_0000,
  parameter int           REFRAC  = 2
) (
  input logic       clk,
  input logic       reset,
  lif_step_if.slave bus
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEAK_SUB  = 3'd1,
    LEAK_MUL  = 3'd2,
    DRIVE_MUL = 3'd3,
    ACCUM     = 3'd4,
    THRESH    = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t        state_r;
  logic [N-1:0]  v_r;
  logic [N-1:0]  i_r;
  logic [N-1:0]  d_r;
  logic [N-1:0]  l_r;
  logic [N-1:0]  g_r;
  logic [N-1:0]  acc_r;
  logic [RW-1:0] refr_r;
  logic [N-1:0]  mul_a_s;
  logic [N-1:0]  mul_b_s;
  logic [N-1:0]  mul_s;

  function automatic logic [N-1:0] sm_norm(input logic sgn, input logic [N-2:0] mag);
    return {sgn & (|mag), mag};
  endfunction

  function automatic logic [N-1:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] sum;
    logic [N-2:0] mag;
    logic         sgn;
    if (a[N-1] == b[N-1]) begin
      sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
      sgn = a[N-1];
    end else if (a[N-2:0] >= b[N-2:0]) begin
      sum = {1'b0, a[N-2:0] - b[N-2:0]};
      sgn = a[N-1];
    end else begin
      sum = {1'b0, b[N-2:0] - a[N-2:0]};
      sgn = b[N-1];
    end
`ifdef LIF_SATURATE_EN
    mag = sum[N-1] ? {(N-1){1'b1}} : sum[N-2:0];
`else
    mag = sum[N-2:0];
`endif
    return sm_norm(sgn, mag);
  endfunction

  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-3:0] prod;
    logic [N-2:0]   mag;
    prod = ({{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]}) >> Q;
`ifdef LIF_SATURATE_EN
    mag = (|prod[2*N-3:N-1]) ? {(N-1){1'b1}} : prod[N-2:0];
`else
    mag = prod[N-2:0];
`endif
    return sm_norm(a[N-1] ^ b[N-1], mag);
  endfunction

  // Both zeros compare equal because magnitudes map to the same signed value.
  function automatic logic sm_ge(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [N:0] sa;
    logic signed [N:0] sb;
    sa = a[N-1] ? -$signed({2'b00, a[N-2:0]}) : $signed({2'b00, a[N-2:0]});
    sb = b[N-1] ? -$signed({2'b00, b[N-2:0]}) : $signed({2'b00, b[N-2:0]});
    return sa >= sb;
  endfunction

  // Operand steering for the time-shared multiplier.
  always_comb begin
    mul_a_s = GAIN;
    mul_b_s = i_r;
    if (state_r == LEAK_MUL) begin
      mul_a_s = LEAK;
      mul_b_s = d_r;
    end else begin
      mul_a_s = GAIN;
      mul_b_s = i_r;
    end
    mul_s = sm_mul(mul_a_s, mul_b_s);
  end

  // Step sequencer, membrane state and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      v_r           <= V_REST;
      i_r           <= {N{1'b0}};
      d_r           <= {N{1'b0}};
      l_r           <= {N{1'b0}};
      g_r           <= {N{1'b0}};
      acc_r         <= {N{1'b0}};
      refr_r        <= {RW{1'b0}};
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.spike     <= 1'b0;
      bus.v_pre     <= {N{1'b0}};
      bus.v_out     <= V_REST;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            i_r          <= bus.i_syn;
            bus.in_ready <= 1'b0;
            state_r      <= LEAK_SUB;
          end
        end
        LEAK_SUB: begin
          d_r     <= sm_add(V_REST, {~v_r[N-1], v_r[N-2:0]});
          state_r <= LEAK_MUL;
        end
        LEAK_MUL: begin
          l_r     <= mul_s;
          state_r <= DRIVE_MUL;
        end
        DRIVE_MUL: begin
          g_r     <= mul_s;
          state_r <= ACCUM;
        end
        ACCUM: begin
          acc_r   <= sm_add(sm_add(v_r, l_r), g_r);
          state_r <= THRESH;
        end
        THRESH: begin
          bus.v_pre     <= acc_r;
          bus.out_valid <= 1'b1;
          state_r       <= DONE;
          // Refractory steps still integrate but force the membrane to V_RESET.
          if (refr_r != {RW{1'b0}}) begin
            bus.spike <= 1'b0;
            bus.v_out <= V_RESET;
            v_r       <= V_RESET;
            refr_r    <= refr_r - {{(RW-1){1'b0}}, 1'b1};
          end else if (sm_ge(acc_r, V_TH)) begin
            bus.spike <= 1'b1;
            bus.v_out <= V_RESET;
            v_r       <= V_RESET;
            refr_r    <= RW'(REFRAC);
          end else begin
            bus.spike <= 1'b0;
            bus.v_out <= acc_r;
            v_r       <= acc_r;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state_r       <= IDLE;
          end
        end
        default: begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state_r       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_step_unit.sv
// Directed bench for lif_step_unit: hand-computed membrane values, latency,
// refractory, stall, mid-flight reset, negative zero and overflow handling.
module tb_lif_step_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lif_step_if #(.N(32)) bus_a ();
  lif_step_if #(.N(32)) bus_b ();

  lif_step_unit dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  lif_step_unit #(.GAIN(32'h0004_0000)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on dut_a; hold > 0 keeps out_ready low for that many DONE cycles.
  task automatic txn(input string tag, input logic [31:0] isyn, input logic [31:0] e_pre,
                     input logic [31:0] e_out, input logic e_spk, input int hold);
    int w;
    int lat;
    w = 0;
    while (!bus_a.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready"}, 32'(bus_a.in_ready), 32'd1);
    bus_a.i_syn     = isyn;
    bus_a.in_valid  = 1'b1;
    bus_a.out_ready = (hold == 0);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    lat = 0;
    while (!bus_a.out_valid && lat < 20) begin
      check({tag, " excl"}, 32'(bus_a.in_ready & bus_a.out_valid), 32'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd5);
    check({tag, " v_pre"}, bus_a.v_pre, e_pre);
    check({tag, " v_out"}, bus_a.v_out, e_out);
    check({tag, " spike"}, 32'(bus_a.spike), 32'(e_spk));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check({tag, " hold v_pre"}, bus_a.v_pre, e_pre);
      check({tag, " hold v_out"}, bus_a.v_out, e_out);
      check({tag, " hold flags"}, {29'd0, bus_a.in_ready, bus_a.out_valid, bus_a.spike},
            {29'd0, 1'b0, 1'b1, e_spk});
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    check({tag, " release"}, {30'd0, bus_a.in_ready, bus_a.out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    int w;
    logic [31:0] e_ovf;
    bus_a.in_valid  = 1'b0;
    bus_a.i_syn     = 32'h0000_0000;
    bus_a.out_ready = 1'b1;
    bus_b.in_valid  = 1'b0;
    bus_b.i_syn     = 32'h0000_0000;
    bus_b.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst v_pre", bus_a.v_pre, 32'h0000_0000);
    check("rst v_out", bus_a.v_out, 32'h8041_0000);
    check("rst flags", {29'd0, bus_a.in_ready, bus_a.out_valid, bus_a.spike}, {29'd0, 1'b1, 1'b0, 1'b0});

    txn("rest",    32'h0000_0000, 32'h8041_0000, 32'h8041_0000, 1'b0, 0);
    txn("spike",   32'h0014_0000, 32'h802D_0000, 32'h8046_0000, 1'b1, 0);
    txn("refr1",   32'h0014_0000, 32'h8031_8003, 32'h8046_0000, 1'b0, 0);
    txn("refr2",   32'h0014_0000, 32'h8031_8003, 32'h8046_0000, 1'b0, 0);
    txn("post",    32'h0000_0000, 32'h8045_8003, 32'h8045_8003, 1'b0, 10);
    txn("negzero", 32'h8000_0000, 32'h8045_0CD3, 32'h8045_0CD3, 1'b0, 0);

    // Abort a transaction while it sits in DRIVE_MUL.
    bus_a.i_syn    = 32'h0014_0000;
    bus_a.in_valid = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort out_valid", 32'(bus_a.out_valid), 32'd0);
    check("abort v_out", bus_a.v_out, 32'h8041_0000);
    check("abort in_ready", 32'(bus_a.in_ready), 32'd1);
    txn("after abort", 32'h0000_0000, 32'h8041_0000, 32'h8041_0000, 1'b0, 0);

    // Overflow on the high-gain instance, still at rest.
`ifdef LIF_SATURATE_EN
    e_ovf = 32'h7FBE_FFFF;
`else
    e_ovf = 32'h3FBF_0000;
`endif
    bus_b.i_syn    = 32'h7000_0000;
    bus_b.in_valid = 1'b1;
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    w = 0;
    while (!bus_b.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("ovf latency", 32'(w), 32'd5);
    check("ovf v_pre", bus_b.v_pre, e_ovf);
    check("ovf spike", 32'(bus_b.spike), 32'd1);
    check("ovf v_out", bus_b.v_out, 32'h8046_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
